// File: rtl/bcd_arb_pkg.sv
// Shared widths and state encoding for the BCD conversion arbiter.
package bcd_arb_pkg;

    localparam int unsigned BIN_W  = 8;
    localparam int unsigned BCD_W  = 12;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned STEP_W = BCD_W + BIN_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// Request/response bundle between N_REQ requesters, one consumer and the shared converter.
interface bcd_conv_arbiter_if
    import bcd_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
);
    logic [N_REQ-1:0]       req_valid;
    logic [BIN_W*N_REQ-1:0] req_bin;
    logic [N_REQ-1:0]       req_ready;
    logic                   rsp_valid;
    logic [BCD_W-1:0]       rsp_bcd;
    logic [ID_W-1:0]        rsp_id;
    logic                   rsp_ready;
    logic                   busy;

    modport master (
        output req_valid, req_bin, rsp_ready,
        input  req_ready, rsp_valid, rsp_bcd, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_bin, rsp_ready,
        output req_ready, rsp_valid, rsp_bcd, rsp_id, busy
    );
endinterface

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration on {bcd, bin}: add 3 to each digit >= 5, then shift left.
module bcd_dabble_step
    import bcd_arb_pkg::*;
(
    input  logic [STEP_W-1:0] i_vec,
    output logic [STEP_W-1:0] o_vec_c
);
    logic [STEP_W-1:0] w_adj;

    always_comb begin
        w_adj = i_vec;
        for (int unsigned d = 0; d < 3; d++) begin
            if (i_vec[BIN_W + 4*d +: 4] >= 4'd5) begin
                w_adj[BIN_W + 4*d +: 4] = i_vec[BIN_W + 4*d +: 4] + 4'd3;
            end
        end
        o_vec_c = {w_adj[STEP_W-2:0], 1'b0};
    end
endmodule

// File: rtl/bcd_conv_arbiter.sv
// Arbitrates N_REQ requesters onto one 8-cycle binary-to-BCD converter.
// Define BCD_ARB_ROUND_ROBIN_EN for round-robin grant; default is fixed priority (lowest index).
module bcd_conv_arbiter
    import bcd_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
)(
    input  logic                 clk,
    input  logic                 rst,
    bcd_conv_arbiter_if.slave    bus
);
    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [STEP_W-1:0]   r_work;
    logic                r_rsp_valid;
    logic [BCD_W-1:0]    r_rsp_bcd;
    logic [ID_W-1:0]     r_rsp_id;

    logic [N_REQ-1:0]    w_grant;
    logic                w_hit;
    logic [ID_W-1:0]     w_idx;
    logic [ID_W-1:0]     w_win_id;
    logic [STEP_W-1:0]   w_step;
    logic [BIN_W-1:0]    w_bin [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_bin
        assign w_bin[g] = bus.req_bin[g*BIN_W +: BIN_W];
    end

`ifdef BCD_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] r_ptr;

    function automatic int unsigned wrap_idx(input int unsigned a);
        return (a >= N_REQ) ? a - N_REQ : a;
    endfunction
`endif

    // Grant search; only offered while idle and out of reset
    always_comb begin
        w_hit    = 1'b0;
        w_idx    = '0;
        w_win_id = '0;
        w_grant  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
`ifdef BCD_ARB_ROUND_ROBIN_EN
            w_idx = ID_W'(wrap_idx(32'(r_ptr) + k));
`else
            w_idx = ID_W'(k);
`endif
            if (!w_hit && bus.req_valid[w_idx]) begin
                w_hit    = 1'b1;
                w_win_id = w_idx;
            end
        end
        if (r_state == IDLE && !rst && w_hit) begin
            w_grant[w_win_id] = 1'b1;
        end
    end

    bcd_dabble_step u_step (
        .i_vec   (r_work),
        .o_vec_c (w_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_work      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_bcd   <= '0;
            r_rsp_id    <= '0;
`ifdef BCD_ARB_ROUND_ROBIN_EN
            r_ptr       <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        r_work   <= {{BCD_W{1'b0}}, w_bin[w_win_id]};
                        r_rsp_id <= w_win_id;
                        r_cnt    <= '0;
                        r_state  <= CONV;
`ifdef BCD_ARB_ROUND_ROBIN_EN
                        r_ptr    <= ID_W'(wrap_idx(32'(w_win_id) + 32'd1));
`endif
                    end
                end
                CONV: begin
                    r_work <= w_step;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    // Eighth step lands the final digits straight into the result register
                    if (r_cnt == CNT_W'(BIN_W - 1)) begin
                        r_state     <= DONE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_bcd   <= w_step[STEP_W-1 -: BCD_W];
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_bcd   <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_bcd   = r_rsp_bcd;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Scoreboard bench for bcd_conv_arbiter: directed requests push expectations, a negedge monitor pops on each handshake.
module tb_bcd_conv_arbiter;
    localparam int unsigned N_REQ = 4;
    localparam int unsigned ID_W  = 2;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    logic [13:0] exp_q [$];
    logic [13:0] mon_e;

    bcd_conv_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) tb_if ();

    bcd_conv_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (tb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp_v, $time);
        end
    endtask

    // Monitor: grant one-hot every cycle, and score each response handshake
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (!$onehot0(tb_if.req_ready)) begin
                failures++;
                $display("FAIL req_ready_onehot actual=%b expected=onehot0", tb_if.req_ready);
            end
            if (tb_if.rsp_valid && tb_if.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp actual id=%0d bcd=%h expected=none",
                             tb_if.rsp_id, tb_if.rsp_bcd);
                end else begin
                    mon_e = exp_q.pop_front();
                    checks += 2;
                    if (tb_if.rsp_bcd !== mon_e[11:0]) begin
                        failures++;
                        $display("FAIL rsp_bcd actual=%h expected=%h", tb_if.rsp_bcd, mon_e[11:0]);
                    end
                    if (tb_if.rsp_id !== mon_e[13:12]) begin
                        failures++;
                        $display("FAIL rsp_id actual=%0d expected=%0d", tb_if.rsp_id, mon_e[13:12]);
                    end
                end
            end
        end
    end

    task automatic do_req(input int ch, input logic [7:0] bin, input bit push, output int acc);
        bit got;
        got = 1'b0;
        tb_if.req_bin[ch*8 +: 8] = bin;
        tb_if.req_valid[ch]      = 1'b1;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (tb_if.req_ready[ch]) got = 1'b1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=no_grant expected=grant ch=%0d", ch);
        end else if (push) begin
            exp_q.push_back({2'(ch), to_bcd(int'(bin))});
        end
        @(posedge clk);
        #1;
        acc = cyc;
        tb_if.req_valid[ch] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tb_if.busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=pending%0d expected=0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [1:0]  arb_ids [5];
    logic [11:0] arb_bcd [4];
    int          acc, first_acc, last_acc;
    bit          seen;

    initial begin
        rst               = 1'b1;
        tb_if.req_valid   = '0;
        tb_if.req_bin     = '0;
        tb_if.rsp_ready   = 1'b1;
`ifdef BCD_ARB_ROUND_ROBIN_EN
        arb_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
        arb_ids = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
        arb_bcd = '{12'h010, 12'h020, 12'h030, 12'h040};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(tb_if.rsp_valid), 32'd0);
        chk("rst_rsp_bcd",   32'(tb_if.rsp_bcd),   32'd0);
        chk("rst_rsp_id",    32'(tb_if.rsp_id),    32'd0);
        chk("rst_busy",      32'(tb_if.busy),      32'd0);
        chk("rst_req_ready", 32'(tb_if.req_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ch0 255 with latency check
        do_req(0, 8'd255, 1'b1, acc);
        chk("busy_conv", 32'(tb_if.busy), 32'd1);
        repeat (7) @(posedge clk);
        #1;
        chk("lat_e7_valid", 32'(tb_if.rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_e8_valid", 32'(tb_if.rsp_valid), 32'd1);
        chk("lat_e8_bcd",   32'(tb_if.rsp_bcd),   32'h255);
        drain();

        // Full operand sweep on ch1, back-to-back
        for (int v = 0; v < 256; v++) begin
            do_req(1, 8'(v), 1'b1, acc);
            if (v == 0)   first_acc = acc;
            if (v == 255) last_acc  = acc;
        end
        chk("sweep_spacing", 32'(last_acc - first_acc), 32'd2550);
        drain();

        // Consumer stall in DONE, with ch0 poking during the stall
        tb_if.rsp_ready = 1'b0;
        do_req(3, 8'd123, 1'b1, acc);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (tb_if.rsp_valid) seen = 1'b1;
        end
        chk("stall_reach_done", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        tb_if.req_bin[7:0]  = 8'd77;
        tb_if.req_valid[0]  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid",     32'(tb_if.rsp_valid), 32'd1);
            chk("stall_bcd",       32'(tb_if.rsp_bcd),   32'h123);
            chk("stall_id",        32'(tb_if.rsp_id),    32'd3);
            chk("stall_req_ready", 32'(tb_if.req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        tb_if.req_valid[0] = 1'b0;
        tb_if.rsp_ready    = 1'b1;
        @(posedge clk);
        #1;
        chk("release_busy",  32'(tb_if.busy),      32'd0);
        chk("release_valid", 32'(tb_if.rsp_valid), 32'd0);
        chk("release_bcd",   32'(tb_if.rsp_bcd),   32'd0);
        drain();

        // ch2 one-cycle pulse during CONV must be ignored
        do_req(0, 8'd42, 1'b1, acc);
        @(posedge clk);
        #1;
        tb_if.req_bin[23:16] = 8'd99;
        tb_if.req_valid[2]   = 1'b1;
        @(negedge clk);
        chk("pulse_req_ready", 32'(tb_if.req_ready), 32'd0);
        @(posedge clk);
        #1;
        tb_if.req_valid[2] = 1'b0;
        drain();

        // Reset mid-conversion aborts; next request converts cleanly
        do_req(1, 8'd200, 1'b0, acc);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("abort_rsp_valid", 32'(tb_if.rsp_valid), 32'd0);
        chk("abort_rsp_bcd",   32'(tb_if.rsp_bcd),   32'd0);
        chk("abort_rsp_id",    32'(tb_if.rsp_id),    32'd0);
        chk("abort_busy",      32'(tb_if.busy),      32'd0);
        chk("abort_req_ready", 32'(tb_if.req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_req(2, 8'd57, 1'b1, acc);
        drain();

        // All four requesters held valid
        pulse_reset();
        tb_if.req_bin   = {8'd40, 8'd30, 8'd20, 8'd10};
        tb_if.req_valid = 4'b1111;
        for (int a = 0; a < 5; a++) begin
            seen = 1'b0;
            for (int n = 0; n < 30 && !seen; n++) begin
                @(negedge clk);
                if (tb_if.req_ready != '0) seen = 1'b1;
            end
            chk("arb_grant", 32'(tb_if.req_ready), 32'(4'b0001 << arb_ids[a]));
            if (seen) exp_q.push_back({arb_ids[a], arb_bcd[arb_ids[a]]});
            @(posedge clk);
        end
        #1;
        tb_if.req_valid = '0;
        drain();

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bcd_conv_arbiter.md
BCD_CONV_ARBITER -- requirements
Module: bcd_conv_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one converter (legal 2..8).
REQ-002 Parameter ID_W, default 2, equals clog2(N_REQ).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  N_REQ  per-requester request valid.
REQ-006 req_bin  input  8*N_REQ  per-requester binary operand; requester i uses bits [8i+7:8i].
REQ-007 req_ready  output  N_REQ  one-hot grant/accept strobe; at most one bit high.
REQ-008 rsp_valid  output  1  conversion result valid.
REQ-009 rsp_bcd  output  12  three-digit packed BCD result (hundreds in [11:8]).
REQ-010 rsp_id  output  ID_W  index of the requester that owns rsp_bcd.
REQ-011 rsp_ready  input  1  consumer accepts the result.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states SHALL be IDLE, CONV, DONE; reset state IDLE.
REQ-014 IDLE: req_ready SHALL equal the combinational grant; accept occurs on the edge where a granted req_valid is high; otherwise remain IDLE.
REQ-015 On accept: latch the operand into the shift register, clear the 12-bit BCD accumulator, latch the winner into rsp_id, clear the bit counter, and go to CONV.
REQ-016 CONV: each cycle SHALL perform one double-dabble step: add 3 to every BCD digit >= 5, then shift {bcd,bin} left one bit, bringing in the operand MSB.
REQ-017 CONV SHALL last exactly 8 cycles; on the edge where the counter equals 7, go to DONE.
REQ-018 rsp_valid SHALL be high only in DONE; rsp_bcd and rsp_id SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-019 Latency: if the accept is at edge E0, rsp_valid SHALL be visible after edge E0+8.
REQ-020 DONE: on the edge with rsp_ready=1, go to IDLE; there is no bypass, so the next accept occurs at E0+10 at the earliest.
REQ-021 req_ready SHALL be all-zero in CONV and DONE; req_valid changes there SHALL be ignored.
REQ-022 Requesters hold req_valid and req_bin until accepted; a valid dropped before accept SHALL NOT be converted.
REQ-023 Arithmetic: digit correction SHALL be 4-bit; operand 255 SHALL yield 0x255 without overflow; results SHALL be exact for 0..255.
REQ-024 rsp_bcd SHALL be 0 whenever rsp_valid=0 outside CONV.

Reset
REQ-025 Asserting rst SHALL immediately force state IDLE, counter 0, accumulator 0, rsp_valid 0, rsp_bcd 0, rsp_id 0, req_ready 0, busy 0, and priority pointer 0.
REQ-026 Reset during CONV or DONE SHALL abort the conversion with no response; the first accept after release SHALL convert correctly.

Configuration
REQ-027 Macro BCD_ARB_ROUND_ROBIN_EN: when defined, grant SHALL be round-robin; the search starts at the pointer, and after granting i the pointer becomes (i+1) mod N_REQ.
REQ-028 Without BCD_ARB_ROUND_ROBIN_EN, grant SHALL be fixed priority (lowest index wins), and the pointer logic SHALL be absent.

Structure
REQ-029 Package bcd_arb_pkg SHALL hold BIN_W=8, BCD_W=12, the state enum typedef (IDLE/CONV/DONE), and the counter width constant.
REQ-030 Sub-module bcd_dabble_step (combinational, one add-3-and-shift step on a 20-bit {bcd,bin} vector) SHALL be instantiated once.

Verification
REQ-031 Single request ch0 bin=255 -> rsp_valid after 8 cycles, rsp_bcd=0x255, rsp_id=0.
REQ-032 Exhaustive sweep 0..255 on ch1 with rsp_ready=1 -> every rsp_bcd correct (e.g. 99->0x099, 0->0x000, 100->0x100); 10 cycles per conversion.
REQ-033 ch0..3 continuously valid with 10/20/30/40, RR_EN defined -> rsp_id order 0,1,2,3,0 and bcd 0x010,0x020,0x030,0x040; without the macro -> ch0 repeatedly.
REQ-034 rsp_ready held low 5 cycles in DONE -> rsp_valid, rsp_bcd, and rsp_id stable; req_ready stays 0; IDLE on the release edge.
REQ-035 rst pulsed at CONV cycle 4 of bin=200 -> all outputs 0 at once; a following request with bin=57 -> 0x057.
REQ-036 Pulse req_valid on ch2 for 1 cycle during CONV -> not converted; req_ready[2] never high.
